// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel divider, horizontal/vertical counters and phase FSMs, registered outputs.
// Optional feature macro VGA_TIMING_FRAME_CNT_EN enables the mod-256 completed-frame counter on frame_cnt.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIX_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] col,
    output logic [8:0] row,
    output logic       col0,
    output logic       row0,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [2:0] DIV_LAST = 3'(PIX_DIV - 1);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    function automatic phase_e decode_phase(
        input logic [9:0] cnt,
        input logic [9:0] fp_start,
        input logic [9:0] sync_start,
        input logic [9:0] bp_start
    );
        if (cnt < fp_start) begin
            return PH_ACTIVE;
        end else if (cnt < sync_start) begin
            return PH_FRONT;
        end else if (cnt < bp_start) begin
            return PH_SYNC;
        end else begin
            return PH_BACK;
        end
    endfunction

    logic [2:0] div_q, div_d;
    logic       run_q, run_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    phase_e     hstate_q, hstate_d;
    phase_e     vstate_q, vstate_d;

    logic       pix_en_q, pix_en_d;
    logic [9:0] col_q, col_d;
    logic [8:0] row_q, row_d;
    logic       col0_q, col0_d;
    logic       row0_q, row0_d;
    logic       active_q, active_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    logic tick;
    logic hwrap;
    logic vwrap;
    logic hact;
    logic vact;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q    <= '0;
            run_q    <= 1'b0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            hstate_q <= PH_ACTIVE;
            vstate_q <= PH_ACTIVE;
            pix_en_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            col0_q   <= 1'b0;
            row0_q   <= 1'b0;
            active_q <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            run_q    <= run_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hstate_q <= hstate_d;
            vstate_q <= vstate_d;
            pix_en_q <= pix_en_d;
            col_q    <= col_d;
            row_q    <= row_d;
            col0_q   <= col0_d;
            row0_q   <= row0_d;
            active_q <= active_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

    always_comb begin
        div_d    = tick ? '0 : div_q + 3'd1;
        run_d    = run_q;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        hstate_d = hstate_q;
        vstate_d = vstate_q;
        hwrap    = 1'b0;
        vwrap    = 1'b0;
        hact     = 1'b0;
        vact     = 1'b0;
        pix_en_d = tick;
        col0_d   = 1'b0;
        row0_d   = 1'b0;
        col_d    = col_q;
        row_d    = row_q;
        active_d = active_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;

        if (tick) begin
            run_d = 1'b1;
            // The first pixel after reset presents (0,0) rather than advancing past it.
            if (run_q) begin
                hwrap  = (hcnt_q >= H_LAST);
                hcnt_d = hwrap ? '0 : hcnt_q + 10'd1;
                if (hwrap) begin
                    vwrap  = (vcnt_q >= V_LAST);
                    vcnt_d = vwrap ? '0 : vcnt_q + 10'd1;
                end
            end else begin
                hcnt_d = '0;
                vcnt_d = '0;
            end

            hstate_d = decode_phase(hcnt_d, H_FP_START, H_SYNC_START, H_BP_START);
            vstate_d = decode_phase(vcnt_d, V_FP_START, V_SYNC_START, V_BP_START);

            hact     = (hstate_d == PH_ACTIVE);
            vact     = (vstate_d == PH_ACTIVE);
            active_d = hact && vact;
            col_d    = hact ? hcnt_d : '0;
            row_d    = vact ? vcnt_d[8:0] : '0;
            col0_d   = (hcnt_d == '0) && vact;
            row0_d   = (hcnt_d == '0) && (vcnt_d == '0);
            hsync_d  = (hstate_d == PH_SYNC);
            vsync_d  = (vstate_d == PH_SYNC);
        end
    end

    assign pix_en = pix_en_q;
    assign col    = col_q;
    assign row    = row_q;
    assign col0   = col0_q;
    assign row0   = row0_q;
    assign active = active_q;
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;
    logic       frame_wrap;

    assign frame_wrap = tick && run_q && hwrap && vwrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if (frame_wrap) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule
